// File: rtl/motor_cmd_pkg.sv
// Shared constants, FSM state type and word builder for the
// motor-command SPI master (MOTOR_CMD_ACK_CHECK_EN adds ack word).
package motor_cmd_pkg;

  localparam logic [2:0] OPC_SELECT = 3'd0;
  localparam logic [2:0] OPC_DIR    = 3'd1;
  localparam logic [2:0] OPC_DIV    = 3'd2;
  localparam logic [2:0] OPC_ENA    = 3'd3;
  localparam logic [2:0] OPC_GETHI  = 3'd4;

  localparam logic [2:0] OP_SET_DIR   = 3'd0;
  localparam logic [2:0] OP_SET_DIV   = 3'd1;
  localparam logic [2:0] OP_SET_ENA   = 3'd2;
  localparam logic [2:0] OP_RESET_POS = 3'd3;
  localparam logic [2:0] OP_READ_POS  = 3'd4;

  localparam logic [15:0] ACK_WORD    = 16'h4F4B;
  localparam logic [3:0]  MOTOR_COUNT = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  // Word idx of the sequence for a latched command.
  function automatic logic [15:0] cmd_word(
    input logic [2:0]  op,
    input logic [3:0]  motor,
    input logic [12:0] arg,
    input logic [1:0]  idx
  );
    logic [15:0] w;
    w = {OPC_GETHI, 13'd0};
    if (idx == 2'd0) begin
      w = {OPC_SELECT, 8'd0,
           (op == OP_RESET_POS), motor};
    end else if (idx == 2'd1) begin
      case (op)
        OP_SET_DIR:   w = {OPC_DIR, 12'd0, arg[0]};
        OP_SET_DIV:   w = {OPC_DIV, arg};
        OP_SET_ENA:   w = {OPC_ENA, 12'd0, arg[0]};
        OP_RESET_POS: w = {OPC_SELECT, 9'd0, motor};
        default:      w = {OPC_GETHI, 13'd0};
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/motor_cmd_spi_master_shifter.sv
// 16-bit SPI mode-0 word shifter: SSEL/SCK timing,
// MSB-first MOSI, synchronised MISO capture, done pulse.
module spi_word_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] tx_word,
  input  logic        MISO,
  output logic        SCK,
  output logic        MOSI,
  output logic        SSEL,
  output logic        done,
  output logic [15:0] rx_word
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic        active;
  logic [7:0]  div_cnt;
  logic [5:0]  half;
  logic [15:0] tx_sr;
  logic [1:0]  miso_sync;

  // Two-flop synchroniser on the asynchronous MISO line.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) miso_sync <= 2'b00;
    else          miso_sync <= {miso_sync[0], MISO};
  end

  // Half 0 is setup; even halves end in a rise,
  // odd halves in a fall; half 32 is the trailing hold.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      active  <= 1'b0;
      div_cnt <= 8'd0;
      half    <= 6'd0;
      tx_sr   <= 16'd0;
      rx_word <= 16'd0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
      SSEL    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !active) begin
        active  <= 1'b1;
        div_cnt <= 8'd0;
        half    <= 6'd0;
        tx_sr   <= tx_word;
        MOSI    <= tx_word[15];
        SSEL    <= 1'b0;
        SCK     <= 1'b0;
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= 8'd0;
          half    <= half + 6'd1;
          if (half == 6'd32) begin
            active <= 1'b0;
            SSEL   <= 1'b1;
            done   <= 1'b1;
          end else if (!half[0]) begin
            SCK     <= 1'b1;
            rx_word <= {rx_word[14:0], miso_sync[1]};
          end else begin
            SCK   <= 1'b0;
            tx_sr <= {tx_sr[14:0], 1'b0};
            MOSI  <= tx_sr[14];
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/motor_cmd_spi_master.sv
// Motor-command SPI master: expands one command into SPI words.
// MOTOR_CMD_ACK_CHECK_EN appends an ack-checked GETHI to writes.
module motor_cmd_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [3:0]  cmd_motor,
  input  logic [12:0] cmd_arg,
  output logic        rsp_valid,
  output logic [31:0] rsp_pos,
  output logic        rsp_err,
  output logic        busy,
  output logic        SCK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SSEL
);

  import motor_cmd_pkg::*;

`ifdef MOTOR_CMD_ACK_CHECK_EN
  localparam logic [1:0] WR_LAST = 2'd2;
`else
  localparam logic [1:0] WR_LAST = 2'd1;
`endif

  // Inner gaps exit one cycle early so LOAD fits in the gap;
  // the final gap runs the full length before DONE.
  localparam logic [7:0] GAP_MID  = 8'(GAP_CYCLES - 3);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 2);

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [3:0]  motor_q;
  logic [12:0] arg_q;
  logic        err_q;
  logic        ack_bad;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [7:0]  gap_cnt;
  logic [15:0] pos_lo;
  logic [15:0] pos_hi;
  logic        accept;
  logic        is_last;
  logic        sh_start;
  logic        sh_done;
  logic [15:0] sh_rx;
  logic [15:0] word;
  logic        gap_load;
  logic        cap;
  logic        idx_inc;

  assign cmd_ready = (state == ST_IDLE) && !rsp_valid;
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_last   = (idx_q == last_q);
  assign word      = cmd_word(op_q, motor_q, arg_q, idx_q);

  spi_word_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shift (
    .CLK     (CLK),
    .reset_n (reset_n),
    .start   (sh_start),
    .tx_word (word),
    .MISO    (MISO),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .SSEL    (SSEL),
    .done    (sh_done),
    .rx_word (sh_rx)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    sh_start  = 1'b0;
    gap_load  = 1'b0;
    cap       = 1'b0;
    idx_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (err_q) begin
          state_nxt = ST_DONE;
        end else begin
          sh_start  = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sh_done) begin
          gap_load  = 1'b1;
          cap       = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) begin
          if (is_last) begin
            state_nxt = ST_DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_LOAD;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch, word counter, gap timer, reply capture.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      op_q    <= 3'd0;
      motor_q <= 4'd0;
      arg_q   <= 13'd0;
      err_q   <= 1'b0;
      ack_bad <= 1'b0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
      gap_cnt <= 8'd0;
      pos_lo  <= 16'd0;
      pos_hi  <= 16'd0;
    end else begin
      if (accept) begin
        op_q    <= cmd_op;
        motor_q <= cmd_motor;
        arg_q   <= cmd_arg;
        err_q   <= (cmd_op > OP_READ_POS) ||
                   (cmd_motor >= MOTOR_COUNT);
        ack_bad <= 1'b0;
        idx_q   <= 2'd0;
        unique case (1'b1)
          (cmd_op == OP_READ_POS):  last_q <= 2'd2;
          (cmd_op == OP_RESET_POS): last_q <= 2'd1;
          default:                  last_q <= WR_LAST;
        endcase
      end
      if (idx_inc) idx_q <= idx_q + 2'd1;
      if (gap_load) begin
        gap_cnt <= is_last ? GAP_LAST : GAP_MID;
      end else if (state == ST_GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
      if (cap && op_q == OP_READ_POS) begin
        if (idx_q == 2'd1) pos_lo <= sh_rx;
        if (idx_q == 2'd2) pos_hi <= sh_rx;
      end
`ifdef MOTOR_CMD_ACK_CHECK_EN
      if (cap && idx_q == 2'd2 && op_q != OP_READ_POS &&
          sh_rx != ACK_WORD) begin
        ack_bad <= 1'b1;
      end
`endif
    end
  end

  // Response pulse and position hand-off.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_pos   <= 32'd0;
    end else begin
      rsp_valid <= (state == ST_DONE);
      rsp_err   <= (state == ST_DONE) && (err_q || ack_bad);
      if (state == ST_DONE && !err_q &&
          op_q == OP_READ_POS) begin
        rsp_pos <= {pos_hi, pos_lo};
      end
    end
  end

endmodule

// File: doc/motor_cmd_spi_master.md
# motor_cmd_spi_master

SPI master that issues the 16-bit motor-command word protocol to the stepper-controller CPLD's SPI slave port. It takes one high-level command at a time (set direction, set divider, set enable, reset position, read position), expands it into the required sequence of command words, and returns the captured 32-bit position or an acknowledge status. It sits on the host-side FPGA, between the motion sequencer and the four-wire link (SCK/MOSI/MISO/SSEL) to the CPLD.

## Interface
Parameters:
- CLK_DIV, 4: CLK cycles per SCK half-period; legal range 2..255.
- GAP_CYCLES, 8: CLK cycles SSEL is held high between words; legal range 4..255.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  0=SET_DIR, 1=SET_DIV, 2=SET_ENA, 3=RESET_POS, 4=READ_POS; 5..7 are illegal.
- cmd_motor  in  4  motor index 0..9.
- cmd_arg  in  13  divider for SET_DIV; bit0 for SET_DIR/SET_ENA; ignored otherwise.
- rsp_valid  out  1  one-cycle pulse when a command completes.
- rsp_pos  out  32  position from READ_POS; holds its last value otherwise.
- rsp_err  out  1  valid with rsp_valid: illegal op, motor > 9, or ack mismatch.
- busy  out  1  high from acceptance until rsp_valid.
- SCK  out  1  SPI clock, mode 0 (idle low).
- MOSI  out  1  serial data, MSB first.
- MISO  in  1  serial response data; passes through a 2-flop synchroniser.
- SSEL  out  1  active-low word select.

## Operation
- Word format: [15:13] opcode, remaining bits payload.
  - Opcode 0, SELECT: [4] reset bit, [3:0] motor.
  - Opcode 1, DIR: [0].
  - Opcode 2, DIV: [12:0].
  - Opcode 3, ENA: [0].
  - Opcode 4, GETHI: no payload.
- Slave response rule: the MISO data shifted during word N is the slave's reply to word N-1.
- Word sequences:
  - SET_DIR / SET_DIV / SET_ENA: SELECT(rst=0), then the op word. 2 words.
  - RESET_POS: SELECT(rst=1), then SELECT(rst=0). 2 words.
  - READ_POS: SELECT(rst=0), GETHI, GETHI. 3 words. rsp_pos[15:0] comes from word 2's MISO, rsp_pos[31:16] from word 3's MISO.
  - READ_POS is not atomic: the two halves may straddle a carry. The consumer handles this.
- Illegal op or motor > 9: no SPI activity; rsp_valid and rsp_err pulse 2 cycles after acceptance.
- FSM states:
  - IDLE → LOAD on accept.
  - LOAD → SHIFT: load the shift register with the next word, drive SSEL low.
  - SHIFT → GAP after the 16th SCK falling edge, driving SSEL high.
  - GAP → LOAD if words remain, else → DONE.
  - DONE → IDLE, pulsing rsp_valid.
- A word counter (2 bits) selects the next word from the latched command.
- cmd_* are latched on acceptance; later input changes have no effect.
- Reset mid-operation: all state is abandoned; outputs return to reset values immediately; no response is produced.

## Timing
- Reset values:
  - SCK=0, MOSI=0, SSEL=1.
  - cmd_ready=1, busy=0.
  - rsp_valid=0, rsp_err=0, rsp_pos=0.
- SSEL falls one half-period (CLK_DIV cycles) before the first SCK rise.
- MOSI is valid from SSEL fall and changes only on SCK fall.
- MISO is sampled on the CLK cycle SCK rises, using the synchronised value.
- Word time: 32·CLK_DIV cycles plus CLK_DIV setup, then GAP_CYCLES with SSEL high.
- Command latency, accept → rsp_valid: words·(33·CLK_DIV + GAP_CYCLES) + 2 cycles. With defaults, 2 words = 282 cycles.
- cmd_ready is low from the accept cycle until the cycle after rsp_valid.

## Configuration
- MOTOR_CMD_ACK_CHECK_EN defined:
  - SET_DIR/SET_DIV/SET_ENA append a third word, GETHI.
  - The MISO shifted during that word must equal 16'h4F4B ("OK"); otherwise rsp_err=1.
  - Latency grows by one word.
- Undefined: write commands are 2 words and report rsp_err=0 when legal.

## Structure
- Package motor_cmd_pkg holds:
  - opcode constants (SELECT=0, DIR=1, DIV=2, ENA=3, GETHI=4);
  - cmd_op encodings;
  - ACK_WORD = 16'h4F4B;
  - MOTOR_COUNT = 10;
  - the FSM state enum.
- One sub-module, spi_word_shifter, does 16-bit mode-0 shifting: SCK generation, SSEL timing, MISO capture, and a done pulse. The top FSM sequences words through it.

## Test plan
- SET_DIV, motor 3, arg 0x0123 → MOSI words 0x0003 then 0x4123; rsp_valid at cycle 282; rsp_err=0.
- READ_POS, motor 1, slave model position 0x000AAAAB → words 0x0001, 0x8000, 0x8000; rsp_pos=0x000AAAAB.
- RESET_POS, motor 9 → words 0x0019, 0x0009; SSEL high for exactly 8 cycles between words.
- cmd_op=6 or motor=12 → SSEL stays high; rsp_valid+rsp_err 2 cycles after accept.
- ACK_CHECK_EN: SET_ENA with slave answering 0x4F4B → rsp_err=0; slave answering 0x0000 → rsp_err=1.
- reset_n asserted mid-word 2 of READ_POS → SSEL=1, SCK=0, no rsp_valid; the next command runs normally.
